// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit_pkg
//  Description : Shared encodings, state type and constants for the EX-stage
//                RV32M multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_unit_pkg;

    // M-extension func3 encodings
    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    // Major opcode of register-register ALU instructions (M-ext shares it)
    localparam logic [4:0] c_OP = 5'b01100;

    // Special divide results
    localparam logic [31:0] c_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] c_INT_MIN  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic src_a_signed(input logic [2:0] f3);
        return (f3 == c_F3_MULH) || (f3 == c_F3_MULHSU) ||
               (f3 == c_F3_DIV)  || (f3 == c_F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic src_b_signed(input logic [2:0] f3);
        return (f3 == c_F3_MULH) || (f3 == c_F3_DIV) || (f3 == c_F3_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit_if
//  Description : EX-stage request/response bundle between the pipeline
//                control (master) and the multiply/divide unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             flush;
    logic             hold;
    logic [2:0]       func3;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, flush, hold, func3, op_a, op_b,
        input  stall_req, busy, done, result
    );

    modport slave (
        input  start, flush, hold, func3, op_a, op_b,
        output stall_req, busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_sign_fix.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sign_fix
//  Description : Sign correction of the unsigned engine result and selection
//                of the architectural word (product low/high, quotient,
//                remainder).
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sign_fix
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [2*WIDTH-1:0] i_acc,
    input  wire logic [2:0]         i_func3,
    input  wire logic               i_neg_a,
    input  wire logic               i_neg_b,
    output logic      [WIDTH-1:0]   o_result
);

    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_neg_res;

    // Product and quotient are negative when the operand signs differ;
    // the remainder follows the dividend.
    always_comb begin
        w_neg_res  = i_neg_a ^ i_neg_b;
        w_prod_fix = w_neg_res ? -i_acc : i_acc;
        w_quot_fix = w_neg_res ? -i_acc[WIDTH-1:0] : i_acc[WIDTH-1:0];
        w_rem_fix  = i_neg_a ? -i_acc[2*WIDTH-1:WIDTH] : i_acc[2*WIDTH-1:WIDTH];
    end

    // Pick the word the instruction writes back
    always_comb begin
        o_result = '0;
        unique case (i_func3)
            c_F3_MUL:                        o_result = w_prod_fix[WIDTH-1:0];
            c_F3_MULH, c_F3_MULHSU,
            c_F3_MULHU:                      o_result = w_prod_fix[2*WIDTH-1:WIDTH];
            c_F3_DIV, c_F3_DIVU:             o_result = w_quot_fix;
            default:                         o_result = w_rem_fix;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative radix-2 RV32M multiply/divide unit for the EX
//                stage. Stalls the front of the pipeline while iterating and
//                presents the rd value for one or more DONE cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ex_muldiv_unit_if.slave bus
);

    localparam int                c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opd;
    logic [WIDTH-1:0]     r_result;
    logic [2:0]           r_func3;
    logic                 r_neg_a;
    logic                 r_neg_b;

    logic                 w_stall;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_neg_a_in;
    logic                 w_neg_b_in;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_is_div;
    logic                 w_div_zero;
    logic                 w_div_ovf;
    logic                 w_special;
    logic [WIDTH-1:0]     w_special_res;
    logic [WIDTH:0]       w_add;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_fix_result;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.flush;

    // Operand decode at issue: sign flags, magnitudes and divide special cases
    always_comb begin
        w_neg_a_in    = src_a_signed(bus.func3) && bus.op_a[WIDTH-1];
        w_neg_b_in    = src_b_signed(bus.func3) && bus.op_b[WIDTH-1];
        w_abs_a       = w_neg_a_in ? -bus.op_a : bus.op_a;
        w_abs_b       = w_neg_b_in ? -bus.op_b : bus.op_b;
        w_is_div      = bus.func3[2];
        w_div_zero    = w_is_div && (bus.op_b == '0);
        w_div_ovf     = ((bus.func3 == c_F3_DIV) || (bus.func3 == c_F3_REM)) &&
                        (bus.op_a == c_INT_MIN) && (bus.op_b == c_ALL_ONES);
        w_special     = w_div_zero || w_div_ovf;
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = bus.func3[1] ? bus.op_a : c_ALL_ONES;
        else if (w_div_ovf)
            w_special_res = bus.func3[1] ? '0 : c_INT_MIN;
    end

    // One engine step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
        w_mul_next = {w_add, r_acc[WIDTH-1:1]};
        w_diff     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opd};
        w_div_next = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        w_acc_next = r_func3[2] ? w_div_next : w_mul_next;
    end

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .i_acc    (w_acc_next),
        .i_func3  (r_func3),
        .i_neg_a  (r_neg_a),
        .i_neg_b  (r_neg_b),
        .o_result (w_fix_result)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state and stall/status outputs; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_stall      = 1'b1;
                    w_state_next = w_special ? DONE : BUSY;
                end
            end
            BUSY: begin
                w_busy  = 1'b1;
                w_stall = !bus.flush;
                if (r_count == c_LAST)
                    w_state_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (!bus.hold)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (bus.flush)
            w_state_next = IDLE;
    end

    // Operand latch, iteration and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_result <= '0;
            r_func3  <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
        end else if (w_accept) begin
            r_func3 <= bus.func3;
            r_neg_a <= w_neg_a_in;
            r_neg_b <= w_neg_b_in;
            r_count <= '0;
            r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            r_opd   <= w_is_div ? w_abs_b : w_abs_a;
            if (w_special)
                r_result <= w_special_res;
        end else if ((r_state == BUSY) && !bus.flush) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + 1'b1;
            if (r_count == c_LAST)
                r_result <= w_fix_result;
        end
    end

    assign bus.stall_req = w_stall;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands and func3; computes all eight M-extension operations.
- Holds the pipeline through its stall request until the result is ready, then presents the result to EX result selection for the EX/MEM register.
- Radix-2 engine: one bit per cycle, a shared 64-bit accumulator and a 5-bit counter.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported, and the counter width is derived from it.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- start  input  1  EX holds a valid M-ext instruction (opcode OP, func7[0]=1, not being flushed)
- flush  input  1  control-hazard flush of the EX instruction
- hold  input  1  downstream stall (MEM not accepting)
- func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  WIDTH  rs1 value (after forwarding)
- op_b  input  WIDTH  rs2 value (after forwarding)
- stall_req  output  1  freeze PC, IF/ID and ID/EX
- busy  output  1  engine in BUSY
- done  output  1  result valid this cycle
- result  output  WIDTH  final rd value

Behaviour:
- Reset (rst=0, async): state=IDLE; count=0; acc, operand and result registers 0; sign flags 0.
  - Outputs: stall_req=0, busy=0, done=0, result=0.
  - Reset mid-operation discards the operation immediately.
- States: IDLE, BUSY, DONE.
- stall_req, combinational:
  - (IDLE & start & !flush) | BUSY.
  - Low in DONE, so the pipeline advances on the first edge where DONE & !hold.
- IDLE & start & !flush: latch func3, operand signs and absolute values.
  - Signed sources: MULH both, MULHSU op_a only, DIV/REM both.
  - Special divide cases go straight to DONE (stall_req high 1 cycle) with a fixed result:
    - op_b=0: DIV/DIVU give all-ones; REM/REMU give op_a.
    - Signed op_a=0x80000000, op_b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
  - All other cases: go to BUSY with count=0.
- BUSY runs 32 iterations, one per cycle.
  - Multiply: shift-add on the unsigned magnitudes.
  - Divide: restoring shift-subtract.
  - At count=31: go to DONE and register the sign-corrected result.
  - Sign rules:
    - MUL takes the low word of the corrected 64-bit product; MULH/MULHSU/MULHU take the high word.
    - The quotient is negated when the operand signs differ.
    - The remainder takes the dividend's sign.
- Normal latency: stall_req high for 33 cycles (1 IDLE + 32 BUSY); done on cycle 34.
- DONE: done=1, result stable.
  - hold=1: stay in DONE, result held.
  - hold=0: go to IDLE.
  - A back-to-back M instruction is seen as start in the following IDLE cycle and never restarts the same instruction.
- flush=1 in any state: next state IDLE, busy/done cleared.
  - stall_req is forced 0 in that cycle; it is gated combinationally by flush in IDLE and by the flush override in BUSY.
  - flush has priority over start and hold.
- start while BUSY/DONE: ignored; the operands are already latched.
- hold does not affect BUSY iteration.

Decomposition:
- Shared package holds:
  - the func3 encodings (MUL..REMU);
  - the opcode constant OP=5'b01100;
  - the state enum {IDLE, BUSY, DONE};
  - the special-case constants: all-ones and 0x80000000.
- One sub-module: muldiv_sign_fix. It is combinational: negation of the 64-bit product or quotient/remainder, plus high/low word selection. It is used when entering DONE.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; stall_req high exactly 33 cycles; done 1 cycle after stall_req falls.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with stall_req high exactly 1 cycle:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- flush asserted at BUSY count=10 -> stall_req 0 that cycle, state IDLE next, no done; then a new DIVU 9/3 completes -> 3.
- hold=1 for 4 cycles during DONE -> done and result 0x12 held for all 4 cycles, stall_req=0; then IDLE. Async rst pulse in BUSY -> all outputs 0 immediately.
